// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end for a synchronous ROM: issues fetch_pc, tags the returned word,
// squashes the single wrong-path fetch on redirect, and keeps sticky address/alignment error flags.
module inst_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [1:0]        redirect_mode,
  input  logic [31:0]       redirect_pc,
  input  logic [DATA_W-1:0] rom_douta,
  output logic [ADDR_W-1:0] rom_addra,
  output logic              rom_ena,
  output logic [DATA_W-1:0] inst_code,
  output logic              inst_valid,
  output logic [31:0]       inst_pc,
  output logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_cnt,
  output logic              addr_err,
  output logic              align_err
);

  logic        take;
  logic        out_of_rom;
  logic [31:0] seq_pc;
  logic [31:0] rel_off;
  logic [31:0] target;

  // A redirect raised against a squashed slot has no instruction behind it, so it is dropped.
  assign take       = redirect & inst_valid;
  assign rom_ena    = ~stall | take;
  assign rom_addra  = fetch_pc[ADDR_W+1:2];
  assign inst_code  = rom_douta;
  assign seq_pc     = inst_pc + 32'd4;
  assign rel_off    = {{14{redirect_pc[15]}}, redirect_pc[15:0], 2'b00};
  assign out_of_rom = (fetch_pc[31:ADDR_W+2] != '0);

  always_comb begin
    target = redirect_pc;
    case (redirect_mode)
      2'b01:   target = seq_pc + rel_off;
      2'b10:   target = {seq_pc[31:28], redirect_pc[25:0], 2'b00};
      default: target = redirect_pc;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
      fetch_cnt  <= 32'd0;
      addr_err   <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      if (rom_ena) begin
        fetch_pc   <= take ? {target[31:2], 2'b00} : fetch_pc + 32'd4;
        inst_pc    <= fetch_pc;
        inst_valid <= ~take;
        if (out_of_rom)
          addr_err <= 1'b1;
        if (take && (target[1:0] != 2'b00))
          align_err <= 1'b1;
      end
      if (inst_valid && !stall)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: hand-derived vector tables for the directed scenarios, then
// randomized traffic compared against a behavioural fetch model.
module tb_inst_fetch_unit;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clka = 1'b0;
  logic              rst;
  logic              stall;
  logic              redirect;
  logic [1:0]        redirect_mode;
  logic [31:0]       redirect_pc;
  logic [DATA_W-1:0] rom_douta;
  logic [ADDR_W-1:0] rom_addra;
  logic              rom_ena;
  logic [DATA_W-1:0] inst_code;
  logic              inst_valid;
  logic [31:0]       inst_pc;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_cnt;
  logic              addr_err;
  logic              align_err;

  inst_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h0)) dut (
    .clka(clka), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_mode(redirect_mode), .redirect_pc(redirect_pc), .rom_douta(rom_douta),
    .rom_addra(rom_addra), .rom_ena(rom_ena), .inst_code(inst_code), .inst_valid(inst_valid),
    .inst_pc(inst_pc), .fetch_pc(fetch_pc), .fetch_cnt(fetch_cnt),
    .addr_err(addr_err), .align_err(align_err)
  );

  always #5 clka = ~clka;

  // Synchronous ROM with ROM[i] = i; holds its output while disabled.
  logic [DATA_W-1:0] rom [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) rom[i] = i;
  always @(posedge clka) if (rom_ena) rom_douta <= rom[rom_addra];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state after the most recent clock edge.
  logic [31:0] m_fpc, m_ipc, m_cnt, m_code;
  logic        m_v, m_aerr, m_lerr;
  bit          use_model = 0;

  task automatic model_reset();
    m_fpc = 32'h0; m_ipc = 32'h0; m_cnt = 0; m_v = 0; m_aerr = 0; m_lerr = 0; m_code = 'x;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [1:0] md, input logic [31:0] rp);
    bit          honour, ena;
    logic [31:0] seq, tgt;
    int          off;
    honour = rd && m_v;
    ena    = !st || honour;
    if (m_v && !st) m_cnt = m_cnt + 1;
    if (ena) begin
      seq = m_ipc + 4;
      off = int'($signed(rp[15:0]));
      case (md)
        2'd1:    tgt = seq + 32'(off * 4);
        2'd2:    tgt = (seq & 32'hF000_0000) | ((rp & 32'h03FF_FFFF) * 4);
        default: tgt = rp;
      endcase
      if (m_fpc >= 32'(DEPTH * 4)) m_aerr = 1;
      if (honour && (tgt % 4 != 0)) m_lerr = 1;
      m_code = rom[(m_fpc / 4) % DEPTH];
      m_ipc  = m_fpc;
      m_v    = !honour;
      m_fpc  = honour ? (tgt & 32'hFFFF_FFFC) : m_fpc + 4;
    end
  endtask

  task automatic apply(input logic st, input logic rd, input logic [1:0] md, input logic [31:0] rp,
                       output logic ena_seen);
    stall = st; redirect = rd; redirect_mode = md; redirect_pc = rp;
    #1;
    ena_seen = rom_ena;
    if (use_model) begin
      chk("rom_ena", {31'd0, rom_ena}, {31'd0, (!st || (rd && m_v))});
      chk("rom_addra", {26'd0, rom_addra}, (m_fpc / 4) % DEPTH);
    end
    model_edge(st, rd, md, rp);
    @(posedge clka);
    #1;
    if (use_model) begin
      chk("fetch_pc", fetch_pc, m_fpc);
      chk("inst_pc", inst_pc, m_ipc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_v});
      chk("fetch_cnt", fetch_cnt, m_cnt);
      chk("addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
      chk("align_err", {31'd0, align_err}, {31'd0, m_lerr});
      if (m_v) chk("inst_code", inst_code, m_code);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, ".inst_pc"}, inst_pc, 32'h0);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, ".fetch_cnt"}, fetch_cnt, 32'd0);
    chk({tag, ".addr_err"}, {31'd0, addr_err}, 32'd0);
    chk({tag, ".align_err"}, {31'd0, align_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clka);
    rst = 1; stall = 0; redirect = 0; redirect_mode = 0; redirect_pc = 0;
    #1;
    check_reset_outputs("reset");
    @(negedge clka);
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic st, rd; logic [1:0] md; logic [31:0] rp;
    logic e_ena; logic [31:0] e_fpc, e_ipc; logic e_v; logic [31:0] e_code, e_cnt;
    logic e_lerr, e_aerr;
  } vec_t;

  function automatic vec_t mk(logic st, logic rd, logic [1:0] md, logic [31:0] rp, logic ena,
                              logic [31:0] fpc, logic [31:0] ipc, logic v, logic [31:0] code,
                              logic [31:0] cnt, logic lerr, logic aerr);
    vec_t r;
    r.st = st; r.rd = rd; r.md = md; r.rp = rp; r.e_ena = ena; r.e_fpc = fpc; r.e_ipc = ipc;
    r.e_v = v; r.e_code = code; r.e_cnt = cnt; r.e_lerr = lerr; r.e_aerr = aerr;
    return r;
  endfunction

  task automatic run_row(input string tag, input int idx, input vec_t r);
    logic  ena;
    string p;
    p = $sformatf("%s[%0d]", tag, idx);
    apply(r.st, r.rd, r.md, r.rp, ena);
    chk({p, ".rom_ena"}, {31'd0, ena}, {31'd0, r.e_ena});
    chk({p, ".fetch_pc"}, fetch_pc, r.e_fpc);
    chk({p, ".inst_pc"}, inst_pc, r.e_ipc);
    chk({p, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, r.e_v});
    chk({p, ".inst_code"}, inst_code, r.e_code);
    chk({p, ".fetch_cnt"}, fetch_cnt, r.e_cnt);
    chk({p, ".align_err"}, {31'd0, align_err}, {31'd0, r.e_lerr});
    chk({p, ".addr_err"}, {31'd0, addr_err}, {31'd0, r.e_aerr});
  endtask

  vec_t tab_seq[$];
  vec_t tab_dir[$];

  initial begin
    logic        ena;
    logic [31:0] rp;
    logic [1:0]  md;
    rst = 1; stall = 0; redirect = 0; redirect_mode = 0; redirect_pc = 0;
    model_reset();

    // Sequential fetch from reset: eight free-running cycles.
    for (int i = 0; i < 8; i++)
      tab_seq.push_back(mk(0, 0, 2'd0, 0, 1, 4 * (i + 1), 4 * i, 1, i, i, 0, 0));

    // Stall at 8, relative redirect, region jump under stall, misaligned out-of-ROM jump.
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 4,  0,  1, 0, 0, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 8,  4,  1, 1, 1, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 12, 8,  1, 2, 2, 0, 0));
    tab_dir.push_back(mk(1, 0, 2'd0, 0,            0, 12, 8,  1, 2, 2, 0, 0));
    tab_dir.push_back(mk(1, 0, 2'd0, 0,            0, 12, 8,  1, 2, 2, 0, 0));
    tab_dir.push_back(mk(1, 0, 2'd0, 0,            0, 12, 8,  1, 2, 2, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 16, 12, 1, 3, 3, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 20, 16, 1, 4, 4, 0, 0));
    tab_dir.push_back(mk(0, 1, 2'd1, 32'hFFFE,     1, 12, 20, 0, 5, 5, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 16, 12, 1, 3, 5, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 20, 16, 1, 4, 6, 0, 0));
    tab_dir.push_back(mk(1, 1, 2'd2, 32'h5,        1, 20, 20, 0, 5, 6, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 24, 20, 1, 5, 6, 0, 0));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 28, 24, 1, 6, 7, 0, 0));
    tab_dir.push_back(mk(0, 1, 2'd0, 32'h102,      1, 32'h100, 28, 0, 7, 8, 1, 0));
    tab_dir.push_back(mk(0, 1, 2'd3, 32'h40,       1, 32'h104, 32'h100, 1, 0, 8, 1, 1));
    tab_dir.push_back(mk(0, 0, 2'd0, 0,            1, 32'h108, 32'h104, 1, 1, 9, 1, 1));

    #1;
    check_reset_outputs("initial");
    @(negedge clka);
    rst = 0;

    foreach (tab_seq[i]) run_row("seq", i, tab_seq[i]);
    do_reset();
    foreach (tab_dir[i]) run_row("dir", i, tab_dir[i]);

    // Asynchronous reset mid-cycle while a redirect is being presented.
    stall = 1; redirect = 1; redirect_mode = 2'd0; redirect_pc = 32'h20;
    #2;
    rst = 1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clka);
    rst = 0; stall = 0; redirect = 0;
    model_reset();
    apply(0, 0, 2'd0, 0, ena);
    chk("restart.inst_pc", inst_pc, 32'h0);
    chk("restart.inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("restart.fetch_pc", fetch_pc, 32'h4);
    chk("restart.inst_code", inst_code, 32'h0);

    // Randomized traffic against the model, with periodic resets to re-arm sticky flags.
    use_model = 1;
    for (int n = 0; n < 600; n++) begin
      if (n % 75 == 74) do_reset();
      md = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rp = 32'($urandom_range(0, DEPTH - 1)) * 4;
        5, 6:          rp = 32'($urandom_range(0, 255));
        7:             rp = 32'hFFFF_FFFC;
        8:             rp = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
        default:       rp = $urandom;
      endcase
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, md, rp, ena);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
